// File: rtl/md_unit.sv
// Iterative multiply/divide unit with private HI/LO registers.
// Optional MD_FAST_MUL_EN: single-cycle mult/multu; div/divu stay iterative.
module md_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [5:0]       Funct,
  input  logic             Sign,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rdata
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               div_q, div_d;

  logic             is_mul, is_div, is_mfhi, is_mflo;
  logic             is_mthi, is_mtlo, accept;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   rem_sh, diff, add_sum;
  logic             ge;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  assign is_mul  = Funct[5:1] == 5'b01100;
  assign is_div  = Funct[5:1] == 5'b01101;
  assign is_mfhi = Funct == 6'b010000;
  assign is_mthi = Funct == 6'b010001;
  assign is_mflo = Funct == 6'b010010;
  assign is_mtlo = Funct == 6'b010011;

  assign accept = start & ~flush & (state_q == IDLE);
  assign busy   = state_q != IDLE;
  assign hi     = hi_q;
  assign lo     = lo_q;

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      is_mfhi: rdata = hi_q;
      is_mflo: rdata = lo_q;
      default: rdata = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    div_d   = div_q;
    prod    = '0;
    quo     = '0;
    rem     = '0;

    mag_a = (Sign & A[WIDTH-1]) ? -A : A;
    mag_b = (Sign & B[WIDTH-1]) ? -B : B;

    // Remainder stays below the divisor, so WIDTH+1 bits hold the trial result.
    rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
    diff    = rem_sh - {1'b0, a_q};
    ge      = ~diff[WIDTH];
    add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
            + (acc_q[0] ? {1'b0, a_q} : '0);

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            is_mul: begin
`ifdef MD_FAST_MUL_EN
              prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
              if (Sign & (A[WIDTH-1] ^ B[WIDTH-1]))
                prod = -prod;
              hi_d = prod[2*WIDTH-1:WIDTH];
              lo_d = prod[WIDTH-1:0];
`else
              a_d     = mag_a;
              acc_d   = {{WIDTH{1'b0}}, mag_b};
              neg_d   = Sign & (A[WIDTH-1] ^ B[WIDTH-1]);
              div_d   = 1'b0;
              cnt_d   = CNT_W'(WIDTH);
              state_d = MUL;
`endif
            end
            is_div: begin
              a_d     = mag_b;
              acc_d   = {{WIDTH{1'b0}}, mag_a};
              // Zero divisor: leave quotient unsigned so it reads all ones.
              neg_d   = Sign & (A[WIDTH-1] ^ B[WIDTH-1]) & (|B);
              rneg_d  = Sign & A[WIDTH-1];
              div_d   = 1'b1;
              cnt_d   = CNT_W'(WIDTH);
              state_d = DIV;
            end
            is_mthi: hi_d = A;
            is_mtlo: lo_d = A;
            default: ;
          endcase
        end
      end
      MUL: begin
        acc_d = {add_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1))
          state_d = FIX;
      end
      DIV: begin
        if (ge)
          acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else
          acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1))
          state_d = FIX;
      end
      FIX: begin
        if (div_q) begin
          quo  = acc_q[WIDTH-1:0];
          rem  = acc_q[2*WIDTH-1:WIDTH];
          lo_d = neg_q ? -quo : quo;
          hi_d = rneg_q ? -rem : rem;
        end else begin
          prod = neg_q ? -acc_q : acc_q;
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      div_q   <= div_d;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: mult/div results, latency, move ops,
// reset abort, flush and start-while-busy handling.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic [5:0]  Funct;
  logic        Sign;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] hi, lo, rdata;

  int checks = 0;
  int errors = 0;
  int ncyc;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

`ifdef MD_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = 33;
`endif

  md_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .flush (flush),
    .Funct (Funct),
    .Sign  (Sign),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo),
    .rdata (rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one instruction for one cycle; returns just after the accept edge.
  task automatic issue(input logic [5:0] f, input logic s,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Funct = f; Sign = s; A = a; B = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; Funct = 6'b0;
  endtask

  // Count cycles with busy high, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0;
    Funct = 6'b0; Sign = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    reset = 1'b0;

    // mult -2 * 3
    issue(F_MULT, 1'b1, 32'hFFFFFFFE, 32'd3);
    wait_idle(ncyc);
    chk("mult_lat", ncyc, MUL_LAT);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);

    // multu 0xFFFFFFFE * 3
    issue(F_MULTU, 1'b0, 32'hFFFFFFFE, 32'd3);
    wait_idle(ncyc);
    chk("multu_lat", ncyc, MUL_LAT);
    chk("multu_hi", hi, 32'h00000002);
    chk("multu_lo", lo, 32'hFFFFFFFA);

    // div -7 / 2
    issue(F_DIV, 1'b1, 32'hFFFFFFF9, 32'd2);
    wait_idle(ncyc);
    chk("div_lat", ncyc, 33);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    // divu 100 / 7
    issue(F_DIVU, 1'b0, 32'd100, 32'd7);
    wait_idle(ncyc);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    // divu by zero
    issue(F_DIVU, 1'b0, 32'd7, 32'd0);
    wait_idle(ncyc);
    chk("dvz_lat", ncyc, 33);
    chk("dvz_lo", lo, 32'hFFFFFFFF);
    chk("dvz_hi", hi, 32'd7);

    // signed div by zero, negative dividend
    issue(F_DIV, 1'b1, 32'hFFFFFFF9, 32'd0);
    wait_idle(ncyc);
    chk("sdvz_lo", lo, 32'hFFFFFFFF);
    chk("sdvz_hi", hi, 32'hFFFFFFF9);

    // signed overflow
    issue(F_DIV, 1'b1, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(ncyc);
    chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_hi", hi, 32'h0);

    // mthi / mtlo / mfhi / mflo
    issue(F_MTHI, 1'b0, 32'h12345678, 32'h0);
    chk("mthi_busy", {31'b0, busy}, 32'd0);
    chk("mthi_hi", hi, 32'h12345678);
    issue(F_MTLO, 1'b0, 32'hCAFEF00D, 32'h0);
    chk("mtlo_lo", lo, 32'hCAFEF00D);
    Funct = F_MFHI;
    #1;
    chk("mfhi_rdata", rdata, 32'h12345678);
    Funct = F_MFLO;
    #1;
    chk("mflo_rdata", rdata, 32'hCAFEF00D);
    Funct = F_DIV;
    #1;
    chk("other_rdata", rdata, 32'h0);
    Funct = 6'b0;

    // start while busy is ignored
    issue(F_DIVU, 1'b0, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    issue(F_MULTU, 1'b0, 32'd5, 32'd9);
    wait_idle(ncyc);
    chk("bsy_lat", ncyc, 29);
    chk("bsy_lo", lo, 32'd14);
    chk("bsy_hi", hi, 32'd2);

    // flush mid-operation does not abort
    issue(F_DIVU, 1'b0, 32'd50, 32'd8);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_idle(ncyc);
    chk("flmid_lo", lo, 32'd6);
    chk("flmid_hi", hi, 32'd2);

    // reset 10 cycles into a div
    issue(F_DIVU, 1'b0, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rmid_busy", {31'b0, busy}, 32'd0);
    chk("rmid_hi", hi, 32'h0);
    chk("rmid_lo", lo, 32'h0);

    // start with flush: no accept
    @(negedge clk);
    flush = 1'b1;
    issue(F_DIVU, 1'b0, 32'd9, 32'd2);
    chk("fl_busy", {31'b0, busy}, 32'd0);
    flush = 1'b1;
    issue(F_MTHI, 1'b0, 32'hDEADBEEF, 32'd0);
    flush = 1'b0;
    chk("fl_hi", hi, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("fl_busy2", {31'b0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
